// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-NUM_OUT stream demultiplexer with packet route lock
//
// Purpose
//   Routes each accepted input beat to the output chosen by in_sel. The route is
//   sampled on the first beat of a packet and held until the in_last beat. Each
//   output has one register stage and drains independently. Packets that start
//   with an out-of-range in_sel are accepted and discarded, and err_sel pulses.
//
// Ports
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready               input handshake
//   in_data/in_last/in_sel          input beat, end-of-packet flag, destination
//   out_valid/out_ready             per-output handshake (NUM_OUT bits)
//   out_data                        flattened, output i at [i*DATA_W +: DATA_W]
//   out_last                        per-output end-of-packet flag
//   err_sel                         1-cycle pulse on a first beat with in_sel >= NUM_OUT
//   busy                            high while a multi-beat packet is in progress
//   out_cnt                         per-output handshake counters, flattened by CNT_W
//
// Configuration
//   STREAM_DEMUX_CNT_EN             builds the per-output counters; otherwise out_cnt is 0

module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic                      err_sel,
  output logic                      busy,
  output logic [NUM_OUT*CNT_W-1:0]  out_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // One extra bit so NUM_OUT itself is representable when 2**SEL_W == NUM_OUT.
  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

  logic [0:0]                state_q, state_d;
  logic [SEL_W-1:0]          lock_sel_q, lock_sel_d;
  logic                      drop_q, drop_d;
  logic [NUM_OUT-1:0]        out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0]        out_last_q, out_last_d;
  logic [NUM_OUT*DATA_W-1:0] out_data_q, out_data_d;
  logic                      err_sel_q, err_sel_d;

  logic                      sel_bad;
  logic [SEL_W-1:0]          target;
  logic                      tgt_drop;
  logic [NUM_OUT-1:0]        tgt_hot;
  logic [NUM_OUT-1:0]        push;
  logic                      in_ready_c;
  logic                      accept;

  // Routing and ready: in IDLE the live in_sel decides, in BUSY the locked one.
  always_comb begin
    sel_bad = ({1'b0, in_sel} >= NUM_OUT_W);
    if (state_q == BUSY) begin
      target   = lock_sel_q;
      tgt_drop = drop_q;
    end else begin
      target   = in_sel;
      tgt_drop = sel_bad;
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      tgt_hot[i] = (target == SEL_W'(i));
    end
    // A dropped beat never needs space, so it is always accepted.
    in_ready_c = tgt_drop | (|(tgt_hot & (~out_valid_q | out_ready)));
    accept     = in_valid & in_ready_c;
    push       = (accept && !tgt_drop) ? tgt_hot : '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (push[i]) begin
        out_valid_d[i]                  = 1'b1;
        out_data_d[i*DATA_W +: DATA_W]  = in_data;
        out_last_d[i]                   = in_last;
      end else if (out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end

    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    drop_d     = drop_q;
    err_sel_d  = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        err_sel_d = sel_bad;
        // Single-beat packets never leave IDLE.
        if (!in_last) begin
          state_d    = BUSY;
          lock_sel_d = in_sel;
          drop_d     = sel_bad;
        end
      end else if (in_last) begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_sel_q  <= '0;
      drop_q      <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_sel_q  <= lock_sel_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_sel_q   <= err_sel_d;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [NUM_OUT*CNT_W-1:0] cnt_q, cnt_d;

  // Counters wrap naturally at 2**CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (out_valid_q[i] && out_ready[i]) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`else
  assign out_cnt = '0;
`endif

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_sel   = err_sel_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux (NUM_OUT=2, SEL_W=2, CNT_W=4)

module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [1:0]  in_sel;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_last;
  logic        err_sel;
  logic        busy;
  logic [7:0]  out_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  stream_demux #(.DATA_W(8), .NUM_OUT(2), .SEL_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_sel(err_sel), .busy(busy), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = '0; out_ready = '0;
    tick; tick;
    n_checks++; if (out_valid !== 2'b00) $display("FAIL reset_valid: got %b exp 00", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0) $display("FAIL reset_data: got %h exp 0000", out_data); else n_pass++;
    n_checks++; if (out_last !== 2'b00) $display("FAIL reset_last: got %b exp 00", out_last); else n_pass++;
    n_checks++; if (err_sel !== 1'b0) $display("FAIL reset_err: got %b exp 0", err_sel); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (out_cnt !== 8'h0) $display("FAIL reset_cnt: got %h exp 00", out_cnt); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", in_ready); else n_pass++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_beats;
    out_ready = 2'b11;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11; in_last = 1'b1;
    tick;
    n_checks++; if (out_valid !== 2'b01) $display("FAIL single_v0: got %b exp 01", out_valid); else n_pass++;
    n_checks++; if (out_data[7:0] !== 8'h11) $display("FAIL single_d0: got %h exp 11", out_data[7:0]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy0: got %b exp 0", busy); else n_pass++;
    in_sel = 2'd1; in_data = 8'h22;
    tick;
    n_checks++; if (out_valid !== 2'b10) $display("FAIL single_v1: got %b exp 10", out_valid); else n_pass++;
    n_checks++; if (out_data[15:8] !== 8'h22) $display("FAIL single_d1: got %h exp 22", out_data[15:8]); else n_pass++;
    n_checks++; if (out_last[1] !== 1'b1) $display("FAIL single_l1: got %b exp 1", out_last[1]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy1: got %b exp 0", busy); else n_pass++;
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 2'b00) $display("FAIL single_drain: got %b exp 00", out_valid); else n_pass++;
  endtask

  task automatic test_packet_lock;
    out_ready = 2'b11;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA0; in_last = 1'b0;
    tick;
    n_checks++; if (out_valid !== 2'b10 || out_data[15:8] !== 8'hA0) $display("FAIL pkt_b1: got v=%b d=%h exp v=10 d=a0", out_valid, out_data[15:8]); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL pkt_busy1: got %b exp 1", busy); else n_pass++;
    in_sel = 2'd0; in_data = 8'hA1;
    tick;
    n_checks++; if (out_valid !== 2'b10 || out_data[15:8] !== 8'hA1 || out_last[1] !== 1'b0) $display("FAIL pkt_b2: got v=%b d=%h l=%b exp v=10 d=a1 l=0", out_valid, out_data[15:8], out_last[1]); else n_pass++;
    in_data = 8'hA2; in_last = 1'b1;
    tick;
    n_checks++; if (out_valid !== 2'b10 || out_data[15:8] !== 8'hA2 || out_last[1] !== 1'b1) $display("FAIL pkt_b3: got v=%b d=%h l=%b exp v=10 d=a2 l=1", out_valid, out_data[15:8], out_last[1]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL pkt_busy3: got %b exp 0", busy); else n_pass++;
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 2'b10;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hB0; in_last = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_empty: got %b exp 1", in_ready); else n_pass++;
    tick;
    in_data = 8'hB1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b exp 0", in_ready); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'hB0 || in_ready !== 1'b0) $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b exp v=1 d=b0 rdy=0", k, out_valid[0], out_data[7:0], in_ready); else n_pass++;
    end
    out_ready = 2'b11;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b exp 1", in_ready); else n_pass++;
    tick;
    n_checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'hB1) $display("FAIL bp_b1: got v=%b d=%h exp v=1 d=b1", out_valid[0], out_data[7:0]); else n_pass++;
    in_data = 8'hB2;
    tick;
    n_checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'hB2) $display("FAIL bp_b2: got v=%b d=%h exp v=1 d=b2", out_valid[0], out_data[7:0]); else n_pass++;
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 2'b00) $display("FAIL bp_drain: got %b exp 00", out_valid); else n_pass++;
  endtask

  task automatic test_bad_sel;
    out_ready = 2'b11;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hC0; in_last = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bad_ready1: got %b exp 1", in_ready); else n_pass++;
    tick;
    n_checks++; if (err_sel !== 1'b1 || out_valid !== 2'b00 || busy !== 1'b1) $display("FAIL bad_b1: got err=%b v=%b busy=%b exp err=1 v=00 busy=1", err_sel, out_valid, busy); else n_pass++;
    in_sel = 2'd0; in_data = 8'hC1; in_last = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bad_ready2: got %b exp 1", in_ready); else n_pass++;
    tick;
    n_checks++; if (err_sel !== 1'b0 || out_valid !== 2'b00 || busy !== 1'b0) $display("FAIL bad_b2: got err=%b v=%b busy=%b exp err=0 v=00 busy=0", err_sel, out_valid, busy); else n_pass++;
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_packet;
    out_ready = 2'b00;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hD0; in_last = 1'b0;
    tick;
    n_checks++; if (out_valid !== 2'b01 || busy !== 1'b1) $display("FAIL rmid_pre: got v=%b busy=%b exp v=01 busy=1", out_valid, busy); else n_pass++;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 2'b00 || busy !== 1'b0) $display("FAIL rmid_async: got v=%b busy=%b exp v=00 busy=0", out_valid, busy); else n_pass++;
    tick;
    rst_n = 1'b1; out_ready = 2'b11;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hE0; in_last = 1'b1;
    tick;
    n_checks++; if (out_valid !== 2'b10 || out_data[15:8] !== 8'hE0 || busy !== 1'b0) $display("FAIL rmid_next: got v=%b d=%h busy=%b exp v=10 d=e0 busy=0", out_valid, out_data[15:8], busy); else n_pass++;
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_counter;
    logic [3:0] exp_c0, exp_c1;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; out_ready = 2'b11;
    in_valid = 1'b1; in_sel = 2'd1; in_last = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_data = 8'(k);
      tick;
    end
    in_valid = 1'b0;
    tick;
`ifdef STREAM_DEMUX_CNT_EN
    exp_c1 = 4'(17 % 16);
`else
    exp_c1 = 4'd0;
`endif
    exp_c0 = 4'd0;
    n_checks++; if (out_cnt[7:4] !== exp_c1) $display("FAIL cnt_out1: got %0d exp %0d", out_cnt[7:4], exp_c1); else n_pass++;
    n_checks++; if (out_cnt[3:0] !== exp_c0) $display("FAIL cnt_out0: got %0d exp %0d", out_cnt[3:0], exp_c0); else n_pass++;
  endtask

  // Reference model: one expected-beat queue per output, packet route state, counters.
  task automatic test_random;
    logic [8:0] expq [2][$];
    int         cnt_m [2];
    bit         in_pkt, exp_err, exp_rdy;
    int         pkt_sel, tsel, gen_sel, gen_left;
    logic [7:0] exp_cnt;

    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    in_pkt = 0; exp_err = 0; pkt_sel = 0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    gen_sel = $urandom_range(0, 3); gen_left = $urandom_range(1, 4);

    for (int cyc = 0; cyc < 1500; cyc++) begin
      out_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      in_valid  = ($urandom_range(0, 2) != 0);
      in_sel    = in_pkt ? 2'($urandom_range(0, 3)) : 2'(gen_sel);
      in_data   = 8'($urandom);
      in_last   = (gen_left == 1);
      @(negedge clk);

      tsel = in_pkt ? pkt_sel : int'(in_sel);
      if (tsel >= 2) exp_rdy = 1;
      else exp_rdy = (expq[tsel].size() == 0) || out_ready[tsel];
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, in_ready, exp_rdy); else n_pass++;
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (out_valid[i] !== (expq[i].size() != 0)) $display("FAIL rnd_valid%0d c%0d: got %b exp %b", i, cyc, out_valid[i], expq[i].size() != 0); else n_pass++;
        if (out_valid[i] && expq[i].size() != 0) begin
          n_checks++;
          if ({out_last[i], out_data[i*8 +: 8]} !== expq[i][0]) $display("FAIL rnd_beat%0d c%0d: got %h exp %h", i, cyc, {out_last[i], out_data[i*8 +: 8]}, expq[i][0]);
          else n_pass++;
        end
      end
      n_checks++; if (err_sel !== exp_err) $display("FAIL rnd_err c%0d: got %b exp %b", cyc, err_sel, exp_err); else n_pass++;
      n_checks++; if (busy !== in_pkt) $display("FAIL rnd_busy c%0d: got %b exp %b", cyc, busy, in_pkt); else n_pass++;
`ifdef STREAM_DEMUX_CNT_EN
      exp_cnt = {4'(cnt_m[1]), 4'(cnt_m[0])};
`else
      exp_cnt = 8'h0;
`endif
      n_checks++; if (out_cnt !== exp_cnt) $display("FAIL rnd_cnt c%0d: got %h exp %h", cyc, out_cnt, exp_cnt); else n_pass++;

      for (int i = 0; i < 2; i++) begin
        if (expq[i].size() != 0 && out_ready[i]) begin
          void'(expq[i].pop_front());
          cnt_m[i] = (cnt_m[i] + 1) % 16;
        end
      end
      exp_err = 0;
      if (in_valid && exp_rdy) begin
        if (!in_pkt) begin
          pkt_sel = int'(in_sel);
          exp_err = (pkt_sel >= 2);
        end
        if (pkt_sel < 2) expq[pkt_sel].push_back({in_last, in_data});
        in_pkt = !in_last;
        gen_left--;
        if (gen_left == 0) begin
          gen_sel  = $urandom_range(0, 3);
          gen_left = $urandom_range(1, 4);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_beats;
    test_packet_lock;
    test_backpressure;
    test_bad_sel;
    test_reset_mid_packet;
    test_counter;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
